object_hit_table: RTL and testbench

//  Parametrised per-pixel hit tester for N scrollable world objects (castle, pipes, blocks).

---
 rtl/object_hit_table.sv | 139 +++++++++++++
 tb/tb_object_hit_table.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/object_hit_table.sv
// Per-pixel hit tester for a table of scrollable world-space object rectangles.
// Two-stage pipeline: screen->world mapping, then parallel rectangle compare with slot-0 priority.
module object_hit_table #(
    parameter  int N_OBJ = 8,
    parameter  int WX_W  = 12,
    parameter  int SCR_W = 10,
    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_sync,
    input  logic [WX_W-1:0]  scroll_in,
    input  logic             pix_valid,
    input  logic [SCR_W-1:0] DrawX,
    input  logic [SCR_W-1:0] DrawY,
    input  logic             obj_we,
    input  logic [IDX_W-1:0] obj_idx,
    input  logic             obj_en,
    input  logic [WX_W-1:0]  obj_x,
    input  logic [SCR_W-1:0] obj_y,
    input  logic [SCR_W-1:0] obj_w,
    input  logic [SCR_W-1:0] obj_h,
    output logic             hit,
    output logic [IDX_W-1:0] hit_id,
    output logic [SCR_W-1:0] loc_x,
    output logic [SCR_W-1:0] loc_y,
    output logic             out_valid,
    output logic             overlap_flag
);

    logic             en_q [N_OBJ];
    logic [WX_W-1:0]  x_q  [N_OBJ];
    logic [SCR_W-1:0] y_q  [N_OBJ];
    logic [SCR_W-1:0] w_q  [N_OBJ];
    logic [SCR_W-1:0] h_q  [N_OBJ];

    logic [WX_W-1:0]  scroll_lat;
    logic [WX_W-1:0]  wx1;
    logic [SCR_W-1:0] y1;
    logic             v1;

    logic [N_OBJ-1:0] in_v;
    logic             any_hit;
    logic             multi_hit;
    logic [IDX_W-1:0] win_id;
    logic [SCR_W-1:0] win_lx;
    logic [SCR_W-1:0] win_ly;

    // Object table; out-of-range indices match no slot and are dropped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                en_q[i] <= 1'b0;
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                w_q[i]  <= '0;
                h_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                if (obj_we && obj_idx == IDX_W'(i)) begin
                    en_q[i] <= obj_en;
                    x_q[i]  <= obj_x;
                    y_q[i]  <= obj_y;
                    w_q[i]  <= obj_w;
                    h_q[i]  <= obj_h;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scroll_lat <= '0;
            wx1        <= '0;
            y1         <= '0;
            v1         <= 1'b0;
        end else begin
            if (frame_sync)
                scroll_lat <= scroll_in;
            wx1 <= WX_W'(DrawX) + scroll_lat;
            y1  <= DrawY;
            v1  <= pix_valid;
        end
    end

    // Right/bottom edges are summed one bit wider so objects at the world edge do not wrap.
    always_comb begin
        in_v = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            in_v[i] = en_q[i]
                   && (wx1 >= x_q[i])
                   && ((WX_W+1)'(wx1) < (WX_W+1)'(x_q[i]) + (WX_W+1)'(w_q[i]))
                   && (y1 >= y_q[i])
                   && ((SCR_W+1)'(y1) < (SCR_W+1)'(y_q[i]) + (SCR_W+1)'(h_q[i]));
        end
    end

    // Scan from the highest slot down so the lowest hit index is the one left standing.
    always_comb begin
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        win_id    = '0;
        win_lx    = '0;
        win_ly    = '0;
        for (int unsigned k = 0; k < N_OBJ; k++) begin
            if (in_v[N_OBJ-1-k]) begin
                if (any_hit)
                    multi_hit = 1'b1;
                any_hit = 1'b1;
                win_id  = IDX_W'(N_OBJ-1-k);
                win_lx  = SCR_W'(wx1 - x_q[N_OBJ-1-k]);
                win_ly  = y1 - y_q[N_OBJ-1-k];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit          <= 1'b0;
            hit_id       <= '0;
            loc_x        <= '0;
            loc_y        <= '0;
            out_valid    <= 1'b0;
            overlap_flag <= 1'b0;
        end else begin
            out_valid <= v1;
            hit       <= any_hit && v1;
            hit_id    <= (any_hit && v1) ? win_id : '0;
            loc_x     <= (any_hit && v1) ? win_lx : '0;
            loc_y     <= (any_hit && v1) ? win_ly : '0;
            if (frame_sync)
                overlap_flag <= 1'b0;
            else if (multi_hit && v1)
                overlap_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_object_hit_table.sv
// Randomised and directed bench for object_hit_table: a rectangle-table reference model
// predicts each pixel's result, and a monitor checks DUT outputs against a queue.
module tb_object_hit_table;

    localparam int NO = 6;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_sync;
    logic [11:0] scroll_in;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic        obj_we;
    logic [2:0]  obj_idx;
    logic        obj_en;
    logic [11:0] obj_x;
    logic [9:0]  obj_y, obj_w, obj_h;
    logic        hit;
    logic [2:0]  hit_id;
    logic [9:0]  loc_x, loc_y;
    logic        out_valid;
    logic        overlap_flag;

    object_hit_table #(.N_OBJ(NO), .WX_W(12), .SCR_W(10)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_sync(frame_sync), .scroll_in(scroll_in),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .obj_we(obj_we), .obj_idx(obj_idx), .obj_en(obj_en), .obj_x(obj_x),
        .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
        .hit(hit), .hit_id(hit_id), .loc_x(loc_x), .loc_y(loc_y),
        .out_valid(out_valid), .overlap_flag(overlap_flag)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned cyc;
        bit          hit;
        int unsigned id, lx, ly;
        bit          ovl;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_pass = 0, n_total = 0;

    // Reference model: the object table as plain integers, plus scroll and sticky overlap.
    bit m_en[NO];
    int m_x[NO], m_y[NO], m_w[NO], m_h[NO];
    int m_scroll;
    bit m_ovl;

    task automatic chk(string nm, longint act, longint expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NO; i++) begin
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
        end
        m_scroll = 0;
        m_ovl    = 0;
    endtask

    always @(posedge Clk) begin
        exp_t e;
        cyc++;
        #1;
        if (Reset_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("hit", hit, e.hit);
                    chk("hit_id", hit_id, e.id);
                    chk("loc_x", loc_x, e.lx);
                    chk("loc_y", loc_y, e.ly);
                    chk("overlap_flag", overlap_flag, e.ovl);
                end
            end else begin
                chk("idle_hit", hit, 0);
            end
        end
    end

    task automatic idle(int n);
        pix_valid = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    task automatic pix(int x, int y);
        exp_t e;
        int wx, cnt;
        DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
        wx = x + m_scroll;
        cnt = 0;
        e.hit = 0; e.id = 0; e.lx = 0; e.ly = 0;
        for (int i = 0; i < NO; i++) begin
            if (m_en[i] && wx >= m_x[i] && wx < m_x[i] + m_w[i] &&
                y >= m_y[i] && y < m_y[i] + m_h[i]) begin
                if (cnt == 0) begin
                    e.hit = 1; e.id = i; e.lx = (wx - m_x[i]) % 1024; e.ly = y - m_y[i];
                end
                cnt++;
            end
        end
        if (cnt >= 2) m_ovl = 1;
        e.ovl = m_ovl;
        e.cyc = cyc + 2;
        q.push_back(e);
        @(negedge Clk);
        pix_valid = 1'b0;
    endtask

    task automatic wr(int idx, bit en, int x, int y, int w, int h);
        idle(2);
        obj_we = 1'b1; obj_idx = 3'(idx); obj_en = en;
        obj_x = 12'(x); obj_y = 10'(y); obj_w = 10'(w); obj_h = 10'(h);
        @(negedge Clk);
        obj_we = 1'b0;
        if (idx < NO) begin
            m_en[idx] = en; m_x[idx] = x; m_y[idx] = y; m_w[idx] = w; m_h[idx] = h;
        end
    endtask

    task automatic fsync();
        idle(2);
        frame_sync = 1'b1;
        @(negedge Clk);
        frame_sync = 1'b0;
        m_scroll = scroll_in;
        m_ovl    = 0;
        chk("overlap_after_fsync", overlap_flag, 0);
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NO; i++) wr(i, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset_n = 1'b0; frame_sync = 0; scroll_in = '0; pix_valid = 0;
        DrawX = '0; DrawY = '0; obj_we = 0; obj_idx = '0; obj_en = 0;
        obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0;
        model_clear();
        #1;
        chk("rst_hit", hit, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overlap", overlap_flag, 0);
        chk("rst_loc_x", loc_x, 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Basic rectangle edges
        wr(0, 1, 100, 50, 64, 88);
        pix(99, 50); pix(100, 50); pix(163, 60); pix(164, 60);
        pix(100, 137); pix(100, 138); pix(130, 49);

        // Scroll latching only on frame_sync, and no 10-bit wrap in world X
        wr(1, 1, 1020, 0, 64, 480);
        scroll_in = 12'd1000;
        pix(20, 10);
        fsync();
        pix(20, 10); pix(83, 10); pix(84, 10);
        wr(2, 1, 1600, 0, 64, 480);
        pix(639, 10);

        // Priority and sticky overlap
        scroll_in = 12'd0;
        fsync();
        clear_slots();
        wr(2, 1, 180, 90, 50, 50);
        wr(5, 1, 190, 95, 50, 50);
        pix(200, 100); pix(185, 92); pix(235, 140);
        fsync();
        pix(235, 140); pix(185, 92);
        wr(2, 0, 180, 90, 50, 50);
        pix(200, 100);

        // World-edge object, zero width, out-of-range slot writes
        scroll_in = 12'd3500;
        fsync();
        clear_slots();
        wr(0, 1, 4090, 0, 64, 10);
        pix(595, 5); pix(589, 5); pix(590, 9); pix(590, 10);
        wr(1, 1, 3600, 0, 0, 10);
        pix(100, 5);
        wr(6, 1, 3600, 0, 100, 10);
        wr(7, 1, 3600, 0, 100, 10);
        pix(150, 5);

        // Random streaming with gaps
        for (int r = 0; r < 4; r++) begin
            scroll_in = 12'($urandom_range(0, 3000));
            fsync();
            for (int i = 0; i < NO; i++)
                wr(i, ($urandom % 4) != 0, int'(scroll_in) + $urandom_range(0, 900),
                   $urandom_range(0, 500), $urandom_range(0, 300), $urandom_range(0, 300));
            for (int c = 0; c < 300; c++) begin
                if ($urandom % 4 == 0) idle(1);
                else pix($urandom_range(0, 1023), $urandom_range(0, 700));
            end
        end

        // Asynchronous reset mid-line
        scroll_in = 12'd0;
        fsync();
        clear_slots();
        wr(0, 1, 100, 50, 64, 88);
        pix(100, 50); pix(110, 60);
        DrawX = 10'd120; DrawY = 10'd60; pix_valid = 1'b1;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_hit", hit, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_hit_id", hit_id, 0);
        chk("async_rst_loc_x", loc_x, 0);
        chk("async_rst_loc_y", loc_y, 0);
        chk("async_rst_overlap", overlap_flag, 0);
        q.delete();
        model_clear();
        pix_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        pix(100, 50); pix(120, 60);
        wr(0, 1, 100, 50, 64, 88);
        pix(100, 50); pix(120, 60);

        idle(1);
        for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge Clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
